fetch_seq: RTL and testbench
============================

// Module: fetch_seq
// PURPOSE
//  Instruction fetch sequencer for the 16-bit CPU. Holds the program counter and picks
//  the next PC through a wordmux instance (val0 = sequential, val1 = branch target).
//  Runs a req/ack handshake with instruction memory and presents each fetched word
//  to the decoder on a valid/ready handshake.
// PARAMETERS
//  WIDTH     16       data/address width in bits
//  RESET_PC  16'h0000 PC value loaded on reset
//  INC       1        sequential PC increment
// PORTS
//  i_clk            in   1      clock; all state updates on rising edge
//  i_rst            in   1      reset, asynchronous, active-high
//  i_branch         in   1      redirect request, one-cycle pulse
//  i_branch_target  in   WIDTH  redirect address, sampled when i_branch=1
//  o_mem_req        out  1      memory read request
//  o_mem_addr       out  WIDTH  read address; stable while o_mem_req=1 until ack
//  i_mem_ack        in   1      read data valid on i_mem_data this cycle
//  i_mem_data       in   WIDTH  instruction word from memory
//  o_instr          out  WIDTH  fetched instruction to decoder
//  o_instr_pc       out  WIDTH  address o_instr was fetched from
//  o_instr_valid    out  1      o_instr valid
//  i_instr_ready    in   1      decoder accepts o_instr
//  o_pc             out  WIDTH  current fetch PC
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, state=S_IDLE, redirect flag=0, pending target=0.
//   Outputs: o_mem_req=0, o_instr_valid=0, o_instr=0, o_instr_pc=0, o_mem_addr=o_pc=RESET_PC.
//   Reset asserted mid-transfer aborts it at once. A late ack is ignored.
//  States:
//   S_IDLE: one cycle after reset release, then S_REQ.
//     i_branch here sets pc=target.
//   S_REQ: o_mem_req=1, o_mem_addr=pc.
//     ack, no redirect: o_instr<=i_mem_data, o_instr_pc<=pc, o_instr_valid<=1,
//       pc<=wordmux(sel=0)=pc+INC, go to S_HOLD.
//     i_branch without ack: latch target, set redirect flag.
//       Address stays stable; the request stays high.
//     ack with flag set, or with i_branch in the same cycle: discard data.
//       pc<=target (i_branch this cycle wins over the latched target); clear flag.
//       Stay in S_REQ; the new address is driven the next cycle.
//   S_HOLD: o_mem_req=0, o_instr_valid=1, all instr outputs held.
//     valid&ready: word consumed. o_instr_valid<=0, go to S_REQ.
//     i_branch: pc<=target, o_instr_valid<=0, go to S_REQ.
//       The word is squashed unless ready is also high that cycle.
//       If ready is high, the word counts as consumed and the branch still redirects.
//  Several branches while one is pending: the last target wins.
//  Arithmetic: pc+INC is modulo 2^WIDTH. FFFF+1 wraps to 0000; no flag.
//  Latency:
//   reset release -> first o_mem_req: 2 edges.
//   ack -> o_instr_valid: 1 cycle.
//   Peak rate with zero-wait memory and ready tied high: 1 word per 2 cycles.
//  o_pc always equals the pc register; it equals o_mem_addr.
// STRUCTURE
//  Shared package: state encodings S_IDLE/S_REQ/S_HOLD, WIDTH default, RESET_PC default.
//  Sub-module: one wordmux instance for next-PC select (existing block, unchanged).
//   i_sel = redirect condition, i_val0 = pc+INC, i_val1 = effective target.
//  Everything else is local: FSM, pc register, output register, pending-target register.
// TESTING
//  1 Reset, mem acks the cycle after each req, ready=1.
//    -> Words at 0000, 0001, 0002 appear in order, with o_instr_pc matching.
//    -> o_mem_req first high 2 edges after reset release.
//  2 Ready held 0 for 5 cycles in S_HOLD.
//    -> o_instr and o_instr_pc stable, o_mem_req=0.
//    -> Ready=1 consumes the word; the next req goes to pc+1.
//  3 Branch to 0x0040 while a req to 0x0005 waits 3 cycles for ack.
//    -> Addr stays 0x0005 until ack; the data is dropped, with no valid pulse.
//    -> Next req is at 0x0040.
//  4 Branch to 0x0100 in S_HOLD with ready=0.
//    -> Valid drops next cycle and the word is never consumed; next req at 0x0100.
//    -> Repeat with ready=1: consumed once, and the next req is still at 0x0100.
//  5 RESET_PC=16'hFFFF, zero-wait memory.
//    -> Fetch addresses go FFFF then 0000; no X anywhere.
//  6 i_rst pulsed mid-S_REQ and again in S_HOLD, between clock edges.
//    -> o_mem_req and o_instr_valid go to 0 immediately.
//    -> pc=RESET_PC; a stale ack after release is ignored.

Source files
------------

// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   WIDTH_DEF    : default data/address width
//   RESET_PC_DEF : default PC loaded on reset
//   INC_DEF      : default sequential PC increment
//   state_t      : fetch FSM state encoding (S_IDLE / S_REQ / S_HOLD)
package fetch_seq_pkg;

    localparam int          WIDTH_DEF    = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;
    localparam int          INC_DEF      = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_seq_wordmux.sv
// Two-way word multiplexer used to choose the next PC.
//   i_sel  : 0 selects i_val0, 1 selects i_val1
//   i_val0 : first candidate word
//   i_val1 : second candidate word
//   o_val  : selected word
module wordmux
    import fetch_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_val0,
    input  logic [WIDTH-1:0] i_val1,
    output logic [WIDTH-1:0] o_val
);

    assign o_val = i_sel ? i_val1 : i_val0;

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer for the 16-bit CPU.
// Holds the PC, requests instruction words from memory over a req/ack
// handshake and hands each fetched word to the decoder over valid/ready.
// Ports:
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_branch              : one-cycle redirect request
//   i_branch_target       : redirect address, sampled with i_branch
//   o_mem_req, o_mem_addr : memory read request and address
//   i_mem_ack, i_mem_data : memory read completion and data
//   o_instr, o_instr_pc   : fetched word and the address it came from
//   o_instr_valid         : o_instr valid toward the decoder
//   i_instr_ready         : decoder accepts o_instr
//   o_pc                  : current fetch PC (same as o_mem_addr)
//
// Handshakes: a memory read is complete in the cycle where o_mem_req and
// i_mem_ack are both high; o_mem_addr never changes while o_mem_req is high
// before that cycle. A word is transferred to the decoder in the cycle where
// o_instr_valid and i_instr_ready are both high; o_instr/o_instr_pc stay
// constant while o_instr_valid is high and i_instr_ready is low.
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter int               WIDTH    = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF),
    parameter int               INC      = INC_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_branch,
    input  logic [WIDTH-1:0] i_branch_target,
    output logic             o_mem_req,
    output logic [WIDTH-1:0] o_mem_addr,
    input  logic             i_mem_ack,
    input  logic [WIDTH-1:0] i_mem_data,
    output logic [WIDTH-1:0] o_instr,
    output logic [WIDTH-1:0] o_instr_pc,
    output logic             o_instr_valid,
    input  logic             i_instr_ready,
    output logic [WIDTH-1:0] o_pc
);

    state_t           state;
    state_t           state_next;
    logic             idle_seen;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pending_target;
    logic             redirect_pend;
    logic [WIDTH-1:0] instr_q;
    logic [WIDTH-1:0] instr_pc_q;

    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] eff_target;
    logic             redirect;
    logic [WIDTH-1:0] pc_next;
    logic             pc_load;
    logic             capture;

    // Sequential PC wraps modulo 2^WIDTH through plain truncation.
    assign seq_pc = pc + WIDTH'(INC);

    // A branch arriving this cycle overrides any target latched earlier.
    assign eff_target = i_branch ? i_branch_target : pending_target;

    // redirect_pend can only be set while in S_REQ, so outside S_REQ this
    // reduces to i_branch.
    assign redirect = i_branch | redirect_pend;

    wordmux #(
        .WIDTH (WIDTH)
    ) u_next_pc (
        .i_sel  (redirect),
        .i_val0 (seq_pc),
        .i_val1 (eff_target),
        .o_val  (pc_next)
    );

    // S_REQ with ack either advances sequentially or redirects; the other
    // states only move the PC on a branch.
    assign pc_load = ((state == S_REQ) && i_mem_ack) ||
                     ((state != S_REQ) && i_branch);

    // Data returned for an address that has since been redirected is dropped.
    assign capture = (state == S_REQ) && i_mem_ack && !redirect;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            // idle_seen delays the first request by one full cycle after
            // reset release.
            S_IDLE:  if (idle_seen) state_next = S_REQ;
            S_REQ:   if (i_mem_ack && !redirect) state_next = S_HOLD;
            S_HOLD:  if (i_branch || i_instr_ready) state_next = S_REQ;
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_mem_req     = 1'b0;
        o_instr_valid = 1'b0;
        unique case (state)
            S_REQ:   o_mem_req     = 1'b1;
            S_HOLD:  o_instr_valid = 1'b1;
            default: ;
        endcase
    end

    // PC, pending redirect and fetched-word registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idle_seen      <= 1'b0;
            pc             <= RESET_PC;
            pending_target <= '0;
            redirect_pend  <= 1'b0;
            instr_q        <= '0;
            instr_pc_q     <= '0;
        end else begin
            idle_seen <= 1'b1;

            if (pc_load) begin
                pc <= pc_next;
            end

            // A branch during an outstanding read cannot move the address,
            // so it is remembered until the read completes.
            if (state == S_REQ) begin
                if (i_mem_ack) begin
                    redirect_pend <= 1'b0;
                end else if (i_branch) begin
                    redirect_pend  <= 1'b1;
                    pending_target <= i_branch_target;
                end
            end

            if (capture) begin
                instr_q    <= i_mem_data;
                instr_pc_q <= pc;
            end
        end
    end

    assign o_mem_addr = pc;
    assign o_pc       = pc;
    assign o_instr    = instr_q;
    assign o_instr_pc = instr_pc_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: randomized branches, memory latency and
// decoder back-pressure, plus reset pulses mid-request and mid-hold, and a
// second instance starting at 16'hFFFF to exercise PC wrap.
module tb_fetch_seq;
    import fetch_seq_pkg::*;

    localparam int W = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    logic         branch        = 1'b0;
    logic [W-1:0] branch_target = '0;
    logic         mem_ack       = 1'b0;
    logic [W-1:0] mem_data      = '0;
    logic         instr_ready   = 1'b0;
    logic         mem_req;
    logic [W-1:0] mem_addr;
    logic [W-1:0] instr;
    logic [W-1:0] instr_pc;
    logic         instr_valid;
    logic [W-1:0] pc;

    fetch_seq #(.WIDTH(W), .RESET_PC(16'h0000), .INC(1)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_branch        (branch),
        .i_branch_target (branch_target),
        .o_mem_req       (mem_req),
        .o_mem_addr      (mem_addr),
        .i_mem_ack       (mem_ack),
        .i_mem_data      (mem_data),
        .o_instr         (instr),
        .o_instr_pc      (instr_pc),
        .o_instr_valid   (instr_valid),
        .i_instr_ready   (instr_ready),
        .o_pc            (pc)
    );

    // ---------------- wrap DUT: zero-wait memory, ready tied high ----------------
    logic         w_req;
    logic         w_valid;
    logic [W-1:0] w_addr;
    logic [W-1:0] w_instr;
    logic [W-1:0] w_instr_pc;
    logic [W-1:0] w_pc;
    logic [W-1:0] w_data;

    assign w_data = mem_word(w_addr);

    fetch_seq #(.WIDTH(W), .RESET_PC(16'hFFFF), .INC(1)) dut_wrap (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_branch        (1'b0),
        .i_branch_target (16'h0000),
        .o_mem_req       (w_req),
        .o_mem_addr      (w_addr),
        .i_mem_ack       (w_req),
        .i_mem_data      (w_data),
        .o_instr         (w_instr),
        .o_instr_pc      (w_instr_pc),
        .o_instr_valid   (w_valid),
        .i_instr_ready   (1'b1),
        .o_pc            (w_pc)
    );

    // ---------------- memory contents and target choice ----------------
    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    function automatic logic [W-1:0] pick_target();
        case ($urandom_range(0, 4))
            0:       return 16'h0040;
            1:       return 16'h0100;
            2:       return 16'hFFFF;
            3:       return 16'hFFFE;
            default: return W'($urandom);
        endcase
    endfunction

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];          // addresses of words the decoder should receive, in order
    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] cur_addr = '0;     // model fetch address for the current cycle
    bit           model_live = 1'b0;
    int           exp_req_code = 2;  // 0/1: required o_mem_req this cycle, 2: unconstrained
    bit           squash_now = 1'b0; // held word is killed by a branch this cycle
    bit           final_req  = 1'b0;
    bit           final_done = 1'b0;
    logic [W-1:0] w_exp = 16'hFFFF;
    bit           held = 1'b0;
    logic [W-1:0] h_instr = '0;
    logic [W-1:0] h_pc = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk or posedge rst) begin
        logic [W-1:0] a;
        if (rst) begin
            #1;
            check("rst_mem_req",     W'(mem_req),     '0);
            check("rst_instr_valid", W'(instr_valid), '0);
            check("rst_instr",       instr,           '0);
            check("rst_instr_pc",    instr_pc,        '0);
            check("rst_mem_addr",    mem_addr,        16'h0000);
            check("rst_pc",          pc,              16'h0000);
            check("rst_wrap_pc",     w_pc,            16'hFFFF);
            check("rst_wrap_req",    W'(w_req),       '0);
            w_exp = 16'hFFFF;
            held  = 1'b0;
        end else begin
            // wrap instance: fetch addresses FFFF, 0000, 0001, ...
            if (w_req) check("wrap_addr", w_addr, w_exp);
            if (w_valid) begin
                check("wrap_instr_pc", w_instr_pc, w_exp);
                check("wrap_instr",    w_instr,    mem_word(w_exp));
                w_exp = w_exp + 16'd1;
            end

            // main instance
            if (model_live) begin
                check("pc", pc, cur_addr);
                check("mem_addr", mem_addr, cur_addr);
            end
            if (exp_req_code != 2) check("req_after_rst", W'(mem_req), W'(exp_req_code));
            check("req_valid_excl", W'(mem_req & instr_valid), '0);

            if (instr_valid) begin
                if (held) begin
                    check("hold_instr",    instr,    h_instr);
                    check("hold_instr_pc", instr_pc, h_pc);
                end
                if (instr_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_word: got pc %h expected no word at %0t", instr_pc, $time);
                    end else begin
                        a = exp_q.pop_front();
                        check("word_pc",   instr_pc, a);
                        check("word_data", instr,    mem_word(a));
                    end
                    held = 1'b0;
                end else if (squash_now) begin
                    if (exp_q.size() != 0) a = exp_q.pop_front();
                    held = 1'b0;
                end else begin
                    held    = 1'b1;
                    h_instr = instr;
                    h_pc    = instr_pc;
                end
            end else begin
                held = 1'b0;
            end

            if (final_req && !final_done) begin
                check("queue_drained", W'(exp_q.size()), '0);
                final_done = 1'b1;
            end
        end
    end

    // ---------------- driver + reference model ----------------
    initial begin
        logic [W-1:0] m_addr;
        logic [W-1:0] m_tgt;
        logic [W-1:0] tgt;
        bit           stale;
        int           wait_cnt;
        int           stall_cnt;
        int           post_rst;
        bit           in_req;
        bit           in_hold;
        bit           drain;
        bit           rst_req_done;
        bit           rst_hold_done;

        m_addr        = 16'h0000;
        m_tgt         = '0;
        stale         = 1'b0;
        wait_cnt      = 1;
        stall_cnt     = 0;
        rst_req_done  = 1'b0;
        rst_hold_done = 1'b0;

        #1  rst = 1'b1;
        #22 rst = 1'b0;   // released between edges (posedges at 5, 15, 25, ...)
        post_rst   = 2;
        cur_addr   = m_addr;
        model_live = 1'b1;

        for (int it = 0; it < 3000; it++) begin
            @(posedge clk);
            #1;
            in_req     = mem_req;
            in_hold    = instr_valid;
            cur_addr   = m_addr;
            squash_now = 1'b0;
            drain      = (it >= 2900);
            exp_req_code = (post_rst == 2) ? 0 : (post_rst == 1) ? 1 : 2;
            if (post_rst > 0) post_rst--;

            // asynchronous reset pulse mid-request, later mid-hold; a stale
            // ack is then held across the first edge after release
            if ((it >= 1000 && !rst_req_done && in_req) ||
                (it >= 2000 && !rst_hold_done && in_hold)) begin
                if (in_req) rst_req_done = 1'b1;
                else        rst_hold_done = 1'b1;
                branch      = 1'b0;
                instr_ready = 1'b0;
                mem_ack     = 1'b0;
                exp_req_code = 2;
                #1 rst = 1'b1;
                #2 rst = 1'b0;
                mem_ack  = 1'b1;
                mem_data = W'($urandom);
                exp_q.delete();
                m_addr   = 16'h0000;
                stale    = 1'b0;
                wait_cnt = $urandom_range(0, 3);
                post_rst = 2;
                cur_addr = m_addr;
                continue;
            end

            branch        = drain ? 1'b0 : ($urandom_range(0, 7) == 0);
            tgt           = pick_target();
            branch_target = branch ? tgt : W'($urandom);

            if (drain) begin
                instr_ready = 1'b1;
            end else if (stall_cnt > 0) begin
                instr_ready = 1'b0;
                stall_cnt--;
            end else if ($urandom_range(0, 19) == 0) begin
                instr_ready = 1'b0;
                stall_cnt   = 5;
            end else begin
                instr_ready = ($urandom_range(0, 3) != 0);
            end

            mem_ack = 1'b0;
            if (in_req) begin
                if (wait_cnt == 0) mem_ack = 1'b1;
                else               wait_cnt--;
            end
            mem_data = mem_ack ? mem_word(m_addr) : W'($urandom);

            // Reference: a read yields a word only if no branch was seen
            // since it was issued; a branch always decides the next address.
            if (in_req) begin
                if (mem_ack) begin
                    if (branch) begin
                        m_addr = tgt;
                    end else if (stale) begin
                        m_addr = m_tgt;
                    end else begin
                        exp_q.push_back(m_addr);
                        m_addr = m_addr + 16'd1;
                    end
                    stale    = 1'b0;
                    wait_cnt = drain ? 0 : $urandom_range(0, 3);
                end else if (branch) begin
                    stale = 1'b1;
                    m_tgt = tgt;
                end
            end else if (in_hold) begin
                if (branch) begin
                    m_addr     = tgt;
                    squash_now = !instr_ready;
                end
            end else if (branch) begin
                m_addr = tgt;
            end
        end

        branch      = 1'b0;
        mem_ack     = 1'b0;
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        model_live   = 1'b0;
        exp_req_code = 2;
        repeat (2) @(posedge clk);
        #1;
        final_req = 1'b1;
        for (int k = 0; k < 10 && !final_done; k++) @(posedge clk);
        if (!final_done) begin
            $display("FAIL final_check_timeout: got no final check expected one within 10 cycles");
            $fatal(1, "final check never ran");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
